mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//   Main control FSM of the multicycle MIPS core. Sequences the shared datapath:
//   instruction fetch, decode, execute, memory access and write-back.
//   Supports the core's opcode set (NOP/ADD/SUB/AND/OR/NOR/XOR/SLA/SLL/SRA/SRL/
//   ADDI/SUBI/LD/ST/BEZ/BNE/JMP). Waits on a data-memory ready handshake and
//   counts retired instructions.
// PARAMETERS
//   MEM_TIMEOUT  15  max cycles in MEM_RD/MEM_WR before abort (SRAM_WAIT_EN only)
//   CNT_W        32  width of instr_cnt
// PORTS
//   clk         in   1      core clock; all state changes on posedge
//   rst         in   1      synchronous reset, active-high
//   opcode      in   6      IR[31:26], latched IR contents
//   src1_zero   in   1      register A == 0 (BEZ condition)
//   src_equal   in   1      register A == register B (BNE condition)
//   mem_ready   in   1      data memory completes current access this cycle
//   ir_write    out  1      load IR from instruction memory
//   pc_write    out  1      load PC
//   pc_src      out  1      0: PC+4, 1: PC+4+(sext(IR[15:0])<<2)
//   alu_src_b   out  1      0: register B, 1: sext(IR[15:0])
//   alu_op      out  4      0 ADD,1 SUB,2 AND,3 OR,4 NOR,5 XOR,6 SLA,7 SLL,8 SRA,9 SRL
//   reg_write   out  1      register-file write enable
//   reg_dst     out  1      0: IR[20:16], 1: IR[15:11]
//   wb_sel      out  1      0: ALU result, 1: memory data
//   mem_read    out  1      data-memory read strobe
//   mem_write   out  1      data-memory write strobe
//   illegal     out  1      1-cycle pulse: undefined opcode decoded
//   mem_err     out  1      1-cycle pulse: memory access timed out
//   instr_cnt   out  CNT_W  fetched-instruction count
//   state       out  4      current state, for debug
// BEHAVIOUR
// - Control outputs are Moore-decoded from state and gated to 0 while rst=1.
//   rst: state<=FETCH, instr_cnt<=0, wait counter<=0. Reset mid-access drops
//   the access; no write-back.
// - States / encoding / outputs (unlisted outputs 0):
//   0 FETCH    ir_write=1,pc_write=1,pc_src=0 -> DECODE; instr_cnt++ (wraps)
//   1 DECODE   opcode 000000->FETCH; R-type 000001,000011,000101..001100
//              ->EXEC_R; 100000/100001->EXEC_I; 100100/100101->MEM_ADDR;
//              101000/101001->BRANCH; 101010->JUMP; other: illegal=1 ->FETCH
//   2 EXEC_R   alu_src_b=0, alu_op from opcode (000001 ADD,000011 SUB,000101 AND,
//              000110 OR,000111 NOR,001000 XOR,001001 SLA,001010 SLL,001011 SRA,
//              001100 SRL) -> R_WB
//   3 EXEC_I   alu_src_b=1, alu_op ADD(100000)/SUB(100001) -> I_WB
//   4 R_WB     reg_write=1, reg_dst=1, wb_sel=0 -> FETCH
//   5 I_WB     reg_write=1, reg_dst=0, wb_sel=0 -> FETCH
//   6 MEM_ADDR alu_src_b=1, alu_op=ADD -> MEM_RD (LD) / MEM_WR (ST)
//   7 MEM_RD   mem_read=1, alu_src_b=1, alu_op=ADD -> LD_WB on mem_ready
//   8 MEM_WR   mem_write=1, alu_src_b=1, alu_op=ADD -> FETCH on mem_ready
//   9 LD_WB    reg_write=1, reg_dst=0, wb_sel=1 -> FETCH
//   10 BRANCH  pc_src=1; pc_write = BEZ ? src1_zero : ~src_equal -> FETCH
//   11 JUMP    pc_src=1, pc_write=1 -> FETCH
//   12-15: unused; -> FETCH
// - Latencies: NOP 2, branch/jump 3, R/I-type 4, ST 4+wait, LD 5+wait cycles.
// - opcode sampled in DECODE..end of instruction; IR is stable (ir_write only in FETCH).
// CONFIGURATION
//   SRAM_WAIT_EN defined: MEM_RD/MEM_WR hold until mem_ready=1. A wait counter
//   clears on entry and increments each held cycle. If MEM_TIMEOUT cycles pass
//   with mem_ready=0: mem_err=1 for one cycle, strobes drop, no write-back, ->FETCH.
//   mem_ready and timeout compare in the same cycle: mem_ready wins.
//   SRAM_WAIT_EN undefined: mem_ready ignored; MEM_RD/MEM_WR last exactly
//   1 cycle; no wait counter; mem_err tied 0.
// TESTING
//   1 rst 2 cyc, opcode=000000 -> FETCH,DECODE repeating; pc_write every 2nd
//     cycle; instr_cnt=3 after 6 cycles; all outputs 0 while rst=1
//   2 opcode=000011 (SUB) -> EXEC_R alu_op=1, alu_src_b=0; R_WB reg_write=1,
//     reg_dst=1; back in FETCH on cycle 5
//   3 SRAM_WAIT_EN, LD, mem_ready low 3 cycles -> MEM_RD held 4 cycles with
//     mem_read=1; LD_WB wb_sel=1, reg_write=1
//   4 SRAM_WAIT_EN, ST, mem_ready stuck 0 -> mem_err pulse after 15 MEM_WR
//     cycles; no reg_write; next state FETCH
//   5 BEZ src1_zero=1 -> pc_write=1, pc_src=1; BNE src_equal=1 -> pc_write=0;
//     JMP -> pc_write=1
//   6 opcode=111111 -> illegal pulse in DECODE, then FETCH; rst asserted in
//     MEM_RD -> strobes 0 at once, FETCH after next edge

Source files
------------

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS main control FSM (optional SRAM_WAIT_EN memory wait/timeout)
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             src1_zero,
  input  logic             src_equal,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             wb_sel,
  output logic             mem_read,
  output logic             mem_write,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_R_WB     = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_LD_WB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic       r_valid;
  logic [3:0] r_op;
  logic       c_ir, c_pcw, c_pcs, c_asb, c_rw, c_rd, c_wb, c_mr, c_mw, c_ill;
  logic [3:0] c_aop;

`ifdef SRAM_WAIT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              unused_in;
  assign unused_in = 1'b0;
`else
  // Memory accesses complete in a single cycle, so the handshake and timeout go unused.
  logic unused_in;
  assign unused_in = mem_ready ^ (MEM_TIMEOUT == 0);
`endif

  // R-type opcode to ALU function decode
  always_comb begin
    r_valid = 1'b1;
    r_op    = ALU_ADD;
    case (opcode)
      6'b000001: r_op = 4'd0;
      6'b000011: r_op = 4'd1;
      6'b000101: r_op = 4'd2;
      6'b000110: r_op = 4'd3;
      6'b000111: r_op = 4'd4;
      6'b001000: r_op = 4'd5;
      6'b001001: r_op = 4'd6;
      6'b001010: r_op = 4'd7;
      6'b001011: r_op = 4'd8;
      6'b001100: r_op = 4'd9;
      default:   r_valid = 1'b0;
    endcase
  end

  // Next-state, counters and Moore control decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef SRAM_WAIT_EN
    wait_d  = wait_q;
`endif
    c_ir = 1'b0; c_pcw = 1'b0; c_pcs = 1'b0; c_asb = 1'b0; c_aop = ALU_ADD;
    c_rw = 1'b0; c_rd = 1'b0; c_wb = 1'b0; c_mr = 1'b0; c_mw = 1'b0; c_ill = 1'b0;
    case (state_q)
      S_FETCH: begin
        c_ir    = 1'b1;
        c_pcw   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == 6'b000000)                           state_d = S_FETCH;
        else if (r_valid)                                  state_d = S_EXEC_R;
        else if (opcode == 6'b100000 || opcode == 6'b100001) state_d = S_EXEC_I;
        else if (opcode == 6'b100100 || opcode == 6'b100101) state_d = S_MEM_ADDR;
        else if (opcode == 6'b101000 || opcode == 6'b101001) state_d = S_BRANCH;
        else if (opcode == 6'b101010)                      state_d = S_JUMP;
        else begin
          c_ill   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        c_aop   = r_op;
        state_d = S_R_WB;
      end
      S_EXEC_I: begin
        c_asb   = 1'b1;
        c_aop   = opcode[0] ? ALU_SUB : ALU_ADD;
        state_d = S_I_WB;
      end
      S_R_WB: begin
        c_rw    = 1'b1;
        c_rd    = 1'b1;
        state_d = S_FETCH;
      end
      S_I_WB: begin
        c_rw    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        c_asb   = 1'b1;
        state_d = opcode[0] ? S_MEM_WR : S_MEM_RD;
`ifdef SRAM_WAIT_EN
        wait_d  = '0;
`endif
      end
      S_MEM_RD, S_MEM_WR: begin
        c_asb = 1'b1;
        c_mr  = (state_q == S_MEM_RD);
        c_mw  = (state_q == S_MEM_WR);
`ifdef SRAM_WAIT_EN
        // mem_ready takes priority over a timeout landing in the same cycle
        if (mem_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_LD_WB : S_FETCH;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
`else
        state_d = (state_q == S_MEM_RD) ? S_LD_WB : S_FETCH;
`endif
      end
      S_LD_WB: begin
        c_rw    = 1'b1;
        c_wb    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        c_pcs   = 1'b1;
        c_pcw   = (opcode == 6'b101000) ? src1_zero : ~src_equal;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        c_pcs   = 1'b1;
        c_pcw   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, instruction counter, wait counter and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef SRAM_WAIT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef SRAM_WAIT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // Control outputs are forced low while reset is held so an in-flight access drops at once
  always_comb begin
    ir_write  = c_ir  & ~rst;
    pc_write  = c_pcw & ~rst;
    pc_src    = c_pcs & ~rst;
    alu_src_b = c_asb & ~rst;
    alu_op    = rst ? 4'd0 : c_aop;
    reg_write = c_rw  & ~rst;
    reg_dst   = c_rd  & ~rst;
    wb_sel    = c_wb  & ~rst;
    mem_read  = c_mr  & ~rst;
    mem_write = c_mw  & ~rst;
    illegal   = c_ill & ~rst;
`ifdef SRAM_WAIT_EN
    mem_err   = err_q & ~rst;
`else
    mem_err   = 1'b0 & err_q;
`endif
  end

  assign instr_cnt = cnt_q;
  assign state     = state_q;

endmodule
